// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEPTH_DEFAULT  = 32;

  // state    | meaning
  // ST_IDLE  | waiting for start, pointer holds last position
  // ST_READY | in_ready=1, waiting for a word
  // ST_BYTES | writing the captured word one byte per cycle, MSB first
  // ST_FIN   | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_BYTES = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/imem_byte_ptr.sv
// Byte pointer into instruction memory, kept modulo DEPTH, with wrap detection.
module imem_byte_ptr
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o,
  output logic          wrap_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;

  // An increment out of the top byte rolls over to 0; that roll-over is the wrap event.
  assign wrap_o = inc_i && (ptr_q == PW'(DEPTH - 1));
  assign ptr_o  = AW'(ptr_q);

  // Next pointer: load takes base mod DEPTH (low bits), increment wraps naturally at PW bits.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = PW'(load_addr_i);
    end else if (inc_i) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads 32-bit instruction words into a byte-wide instruction memory, big-endian.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  input  logic [31:0]   in_word,
  input  logic          in_last,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          wrap_err
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic        last_q;
  logic        in_ready_q;
  logic        mem_we_q;
  logic        busy_q;
  logic        done_q;
  logic        wrap_err_q;

  logic        ptr_load;
  logic        ptr_inc;
  logic        ptr_wrap;
  logic [AW-1:0] ptr;
  logic [7:0]  byte_sel;

  assign ptr_load = (state_q == ST_IDLE) && start;
  assign ptr_inc  = (state_q == ST_BYTES);

  imem_byte_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ptr_load),
    .load_addr_i (base_addr),
    .inc_i       (ptr_inc),
    .ptr_o       (ptr),
    .wrap_o      (ptr_wrap)
  );

  // Pick the byte for the current index, MSB first; zero whenever not writing.
  always_comb begin
    byte_sel = 8'h00;
    if (mem_we_q) begin
      case (idx_q)
        2'd0:    byte_sel = word_q[31:24];
        2'd1:    byte_sel = word_q[23:16];
        2'd2:    byte_sel = word_q[15:8];
        default: byte_sel = word_q[7:0];
      endcase
    end
  end

  // Session FSM; every output flop is updated alongside the state so outputs track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_READY;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            wrap_err_q <= 1'b0;
          end
        end
        ST_READY: begin
          if (in_valid) begin
            word_q     <= in_word;
            last_q     <= in_last;
            idx_q      <= '0;
            state_q    <= ST_BYTES;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b1;
          end
        end
        ST_BYTES: begin
          if (ptr_wrap) begin
            wrap_err_q <= 1'b1;
          end
          idx_q <= idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            mem_we_q <= 1'b0;
            if (last_q) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_READY;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          mem_we_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = ptr;
  assign mem_wdata = byte_sel;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap_err  = wrap_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected byte writes are queued by stimulus, popped by a monitor.
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic [31:0]   in_word;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          wrap_err;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .wrap_err  (wrap_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [AW-1:0] exp_ptr;
  int            checks   = 0;
  int            failures = 0;
  int            done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented byte write must match the head of the expected queue.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_we) begin
      chk("in_ready_low_in_bytes", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0d data %02h required=no write t=%0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = exp_ptr;
      e.data = w[31 - 8*i -: 8];
      exp_q.push_back(e);
      exp_ptr = (exp_ptr + 1) % DEPTH;
    end
  endtask

  task automatic start_session(input logic [AW-1:0] b);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_ptr   = b % DEPTH;
  endtask

  // Offer a word; returns #1 after the accepting edge (first BYTES cycle).
  task automatic offer(input logic [31:0] w, input logic l, input int nexp);
    bit ok;
    ok = 1'b0;
    push_word(w, nexp);
    in_valid = 1'b1;
    in_word  = w;
    in_last  = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("accept_within_bound", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_within_bound", 32'(ok), 32'd1);
  endtask

  int acc[3];
  int nacc;
  int d0;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_word   = '0;
    in_last   = 1'b0;
    exp_ptr   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrap_err", 32'(wrap_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    // Two words from base 0
    d0 = done_cnt;
    start_session(0);
    offer(32'h12345678, 1'b0, 4);
    offer(32'hDEADBEEF, 1'b1, 4);
    wait_idle();
    chk("s1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("s1_wrap_err", 32'(wrap_err), 32'd0);
    chk("s1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Base 28: second word wraps to 0..3
    start_session(28);
    offer(32'hA1A2A3A4, 1'b0, 4);
    offer(32'hB1B2B3B4, 1'b1, 4);
    wait_idle();
    chk("s2_wrap_err_set", 32'(wrap_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("s2_wrap_err_sticky", 32'(wrap_err), 32'd1);
    chk("s2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Continuous in_valid from base 16: accept every 5 cycles
    start_session(16);
    @(negedge clk);
    chk("s3_wrap_err_cleared", 32'(wrap_err), 32'd0);
    push_word(32'h01020304, 4);
    push_word(32'h05060708, 4);
    push_word(32'h090A0B0C, 4);
    in_word  = 32'h01020304;
    in_last  = 1'b0;
    in_valid = 1'b1;
    nacc = 0;
    for (int cyc = 0; cyc < 40 && nacc < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (in_valid && in_ready) begin
        acc[nacc] = cyc;
        nacc++;
        @(posedge clk); #1;
        if (nacc == 1) in_word = 32'h05060708;
        if (nacc == 2) begin
          in_word = 32'h090A0B0C;
          in_last = 1'b1;
        end
        if (nacc == 3) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("s3_accept_count", 32'(nacc), 32'd3);
    if (nacc == 3) begin
      chk("s3_gap_1", 32'(acc[1] - acc[0]), 32'd5);
      chk("s3_gap_2", 32'(acc[2] - acc[1]), 32'd5);
    end
    wait_idle();
    chk("s3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during byte index 2
    start_session(20);
    offer(32'hCAFEF00D, 1'b1, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("s4_mem_we_drop", 32'(mem_we), 32'd0);
    chk("s4_busy_drop", 32'(busy), 32'd0);
    chk("s4_in_ready_rst", 32'(in_ready), 32'd0);
    chk("s4_mem_addr_rst", 32'(mem_addr), 32'd0);
    chk("s4_wdata_rst", 32'(mem_wdata), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("s4_no_extra_writes", 32'(exp_q.size()), 32'd0);
    start_session(8);
    offer(32'h11223344, 1'b1, 4);
    wait_idle();
    chk("s4_queue_empty", 32'(exp_q.size()), 32'd0);

    // in_valid in IDLE ignored, start during BYTES ignored
    in_valid = 1'b1;
    in_word  = 32'hFFFFFFFF;
    repeat (5) begin
      @(negedge clk);
      chk("s5_idle_in_ready", 32'(in_ready), 32'd0);
      chk("s5_idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    chk("s5_ptr_held", 32'(mem_addr), 32'd12);
    start_session(0);
    offer(32'h55667788, 1'b0, 4);
    start     = 1'b1;
    base_addr = 24;
    @(posedge clk); #1;
    start     = 1'b0;
    offer(32'h99AABBCC, 1'b1, 4);
    wait_idle();
    chk("s5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single-word session at base 4
    start_session(4);
    offer(32'h000000FF, 1'b1, 4);
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("s6_fin_done", 32'(done), 32'd1);
    chk("s6_fin_busy", 32'(busy), 32'd1);
    chk("s6_fin_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("s6_idle_done", 32'(done), 32'd0);
    chk("s6_idle_busy", 32'(busy), 32'd0);
    chk("s6_wrap_err", 32'(wrap_err), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
